// File: rtl/jedro_1_lsu_pkg.sv
// -----------------------------------------------------------------------------
// jedro_1_lsu_pkg
// Shared definitions for the jedro_1 load/store unit:
//   - access size encodings (LSU_BYTE / LSU_HALF / LSU_WORD, 2'b11 acts as word)
//   - FSM state enum (IDLE / REQ / WAIT)
//   - byte-enable width
//   - helpers that classify and realign the low address bits of a command
// -----------------------------------------------------------------------------
package jedro_1_lsu_pkg;

   localparam int BE_WIDTH = 4;

   typedef enum logic [1:0] {
      LSU_BYTE = 2'b00,
      LSU_HALF = 2'b01,
      LSU_WORD = 2'b10
   } lsu_size_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      REQ  = 2'b01,
      WAIT = 2'b10
   } lsu_state_e;

   // A half must sit on an even byte, a word on a word boundary.
   // The reserved size code 2'b11 behaves like a word.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
      case (size)
         LSU_BYTE: return 1'b0;
         LSU_HALF: return off[0];
         default:  return |off;
      endcase
   endfunction

   // Byte offset actually used for lane selection once the address has been
   // forced onto the natural boundary of the access size.
   function automatic logic [1:0] aligned_off(input logic [1:0] size, input logic [1:0] off);
      case (size)
         LSU_BYTE: return off;
         LSU_HALF: return {off[1], 1'b0};
         default:  return 2'b00;
      endcase
   endfunction

endpackage

// File: rtl/jedro_1_lsu_if.sv
// -----------------------------------------------------------------------------
// jedro_1_lsu_if
// Bundles every non-clock/reset signal of the load/store unit:
//   ctrl_*  : command from the execute stage (valid/ready handshake)
//   data_*  : data-memory bus (req/gnt address phase, rvalid response phase)
//   wpc_*   : register file write port C
//   misaligned_o : misaligned-access pulse
// Modports:
//   master : the LSU itself
//   slave  : the surrounding environment (execute stage, memory, register file)
// -----------------------------------------------------------------------------
interface jedro_1_lsu_if
   import jedro_1_lsu_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5
);

   logic                      ctrl_valid_i;
   logic                      ctrl_ready_o;
   logic                      ctrl_we_i;
   logic [1:0]                ctrl_size_i;
   logic                      ctrl_unsigned_i;
   logic [DATA_WIDTH-1:0]     ctrl_addr_i;
   logic [DATA_WIDTH-1:0]     ctrl_wdata_i;
   logic [REG_ADDR_WIDTH-1:0] ctrl_regdest_i;

   logic                      data_req_o;
   logic                      data_gnt_i;
   logic                      data_we_o;
   logic [BE_WIDTH-1:0]       data_be_o;
   logic [DATA_WIDTH-1:0]     data_addr_o;
   logic [DATA_WIDTH-1:0]     data_wdata_o;
   logic                      data_rvalid_i;
   logic [DATA_WIDTH-1:0]     data_rdata_i;

   logic [REG_ADDR_WIDTH-1:0] wpc_addr_o;
   logic [DATA_WIDTH-1:0]     wpc_data_o;
   logic                      wpc_we_o;

   logic                      misaligned_o;

   modport master (
      input  ctrl_valid_i, ctrl_we_i, ctrl_size_i, ctrl_unsigned_i,
             ctrl_addr_i, ctrl_wdata_i, ctrl_regdest_i,
             data_gnt_i, data_rvalid_i, data_rdata_i,
      output ctrl_ready_o,
             data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
             wpc_addr_o, wpc_data_o, wpc_we_o, misaligned_o
   );

   modport slave (
      output ctrl_valid_i, ctrl_we_i, ctrl_size_i, ctrl_unsigned_i,
             ctrl_addr_i, ctrl_wdata_i, ctrl_regdest_i,
             data_gnt_i, data_rvalid_i, data_rdata_i,
      input  ctrl_ready_o,
             data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
             wpc_addr_o, wpc_data_o, wpc_we_o, misaligned_o
   );

endinterface

// File: rtl/jedro_1_lsu_align.sv
// -----------------------------------------------------------------------------
// jedro_1_lsu_align
// Purely combinational lane logic for the load/store unit.
//   Store half: st_size, st_off, st_wdata -> st_be, st_wdata_aligned
//               (byte/half data replicated across all lanes)
//   Load half : ld_size, ld_off, ld_unsigned, ld_rdata -> ld_data
//               (shift lane down, then sign/zero-extend; word ignores unsigned)
// The two halves are independent so the top can feed the store half from the
// incoming command and the load half from the registered command.
// -----------------------------------------------------------------------------
module jedro_1_lsu_align
   import jedro_1_lsu_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [1:0]            st_size,
   input  logic [1:0]            st_off,
   input  logic [DATA_WIDTH-1:0] st_wdata,
   output logic [BE_WIDTH-1:0]   st_be,
   output logic [DATA_WIDTH-1:0] st_wdata_aligned,

   input  logic [1:0]            ld_size,
   input  logic [1:0]            ld_off,
   input  logic                  ld_unsigned,
   input  logic [DATA_WIDTH-1:0] ld_rdata,
   output logic [DATA_WIDTH-1:0] ld_data
);

   logic [DATA_WIDTH-1:0] byte_rep;
   logic [DATA_WIDTH-1:0] half_rep;
   logic [DATA_WIDTH-1:0] ld_shifted;

   generate
      for (genvar gi = 0; gi < BE_WIDTH; gi++) begin : g_byte_rep
         assign byte_rep[gi*8 +: 8] = st_wdata[7:0];
      end
      for (genvar gi = 0; gi < BE_WIDTH/2; gi++) begin : g_half_rep
         assign half_rep[gi*16 +: 16] = st_wdata[15:0];
      end
   endgenerate

   always_comb begin
      st_be            = '1;
      st_wdata_aligned = st_wdata;
      case (st_size)
         LSU_BYTE: begin
            st_be            = BE_WIDTH'(1) << st_off;
            st_wdata_aligned = byte_rep;
         end
         LSU_HALF: begin
            st_be            = st_off[1] ? 4'b1100 : 4'b0011;
            st_wdata_aligned = half_rep;
         end
         default: ;
      endcase
   end

   assign ld_shifted = ld_rdata >> {ld_off, 3'b000};

   always_comb begin
      ld_data = ld_shifted;
      case (ld_size)
         LSU_BYTE: ld_data = {{24{~ld_unsigned & ld_shifted[7]}},  ld_shifted[7:0]};
         LSU_HALF: ld_data = {{16{~ld_unsigned & ld_shifted[15]}}, ld_shifted[15:0]};
         default: ;
      endcase
   end

endmodule

// File: rtl/jedro_1_lsu.sv
// -----------------------------------------------------------------------------
// jedro_1_lsu
// Load/store unit of the jedro_1 core. Accepts one command at a time, runs one
// req/gnt/rvalid data-memory transaction and writes extended load data to
// register file port C.
// Ports:
//   clk_i  : core clock, rising edge
//   rstn_i : synchronous active-low reset
//   bus    : jedro_1_lsu_if.master (ctrl_*, data_*, wpc_*, misaligned_o)
// Optional feature macro: JEDRO_1_LSU_MISALIGNED_EXC_EN
//   defined   : misaligned commands are accepted, no memory request is made,
//               misaligned_o pulses one cycle after acceptance
//   undefined : misaligned_o is tied low, address is forced onto the natural
//               boundary and the access proceeds normally
// -----------------------------------------------------------------------------
module jedro_1_lsu
   import jedro_1_lsu_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5
) (
   input  logic           clk_i,
   input  logic           rstn_i,
   jedro_1_lsu_if.master  bus
);

   lsu_state_e                state_reg, state_next;
   logic                      ready;
   logic                      accept;
   logic                      issue;
   logic [1:0]                cmd_off;

   logic [BE_WIDTH-1:0]       st_be;
   logic [DATA_WIDTH-1:0]     st_wdata;
   logic [DATA_WIDTH-1:0]     ld_data;

   logic                      data_we_reg;
   logic [BE_WIDTH-1:0]       data_be_reg;
   logic [DATA_WIDTH-1:0]     data_addr_reg;
   logic [DATA_WIDTH-1:0]     data_wdata_reg;
   logic [1:0]                ld_size_reg;
   logic [1:0]                ld_off_reg;
   logic                      ld_unsigned_reg;
   logic                      ld_write_reg;
   logic [REG_ADDR_WIDTH-1:0] regdest_reg;
   logic [REG_ADDR_WIDTH-1:0] wpc_addr_reg;
   logic [DATA_WIDTH-1:0]     wpc_data_reg;
   logic                      wpc_we_reg;

   // Ready is a pure state decode, gated so it reads low while reset is held.
   assign ready   = (state_reg == IDLE) & rstn_i;
   assign accept  = bus.ctrl_valid_i & ready;
   assign cmd_off = aligned_off(bus.ctrl_size_i, bus.ctrl_addr_i[1:0]);

`ifdef JEDRO_1_LSU_MISALIGNED_EXC_EN
   logic cmd_misaligned;
   logic misaligned_reg;

   assign cmd_misaligned   = is_misaligned(bus.ctrl_size_i, bus.ctrl_addr_i[1:0]);
   // A misaligned command is consumed but never reaches the memory bus.
   assign issue            = accept & ~cmd_misaligned;
   assign bus.misaligned_o = misaligned_reg;
`else
   assign issue            = accept;
   assign bus.misaligned_o = 1'b0;
`endif

   // Store half fed from the live command, load half from the captured one.
   jedro_1_lsu_align #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_align (
      .st_size          (bus.ctrl_size_i),
      .st_off           (cmd_off),
      .st_wdata         (bus.ctrl_wdata_i),
      .st_be            (st_be),
      .st_wdata_aligned (st_wdata),
      .ld_size          (ld_size_reg),
      .ld_off           (ld_off_reg),
      .ld_unsigned      (ld_unsigned_reg),
      .ld_rdata         (bus.data_rdata_i),
      .ld_data          (ld_data)
   );

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (issue)              state_next = REQ;
         REQ:     if (bus.data_gnt_i)     state_next = WAIT;
         WAIT:    if (bus.data_rvalid_i)  state_next = IDLE;
         default:                         state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state_reg       <= IDLE;
         data_we_reg     <= 1'b0;
         data_be_reg     <= '0;
         data_addr_reg   <= '0;
         data_wdata_reg  <= '0;
         ld_size_reg     <= LSU_BYTE;
         ld_off_reg      <= 2'b00;
         ld_unsigned_reg <= 1'b0;
         ld_write_reg    <= 1'b0;
         regdest_reg     <= '0;
         wpc_addr_reg    <= '0;
         wpc_data_reg    <= '0;
         wpc_we_reg      <= 1'b0;
      end else begin
         state_reg  <= state_next;
         wpc_we_reg <= 1'b0;
         if (issue) begin
            data_we_reg     <= bus.ctrl_we_i;
            data_be_reg     <= st_be;
            data_addr_reg   <= {bus.ctrl_addr_i[DATA_WIDTH-1:2], 2'b00};
            data_wdata_reg  <= st_wdata;
            ld_size_reg     <= bus.ctrl_size_i;
            ld_off_reg      <= cmd_off;
            ld_unsigned_reg <= bus.ctrl_unsigned_i;
            // x0 is never written; stores never touch the register file.
            ld_write_reg    <= ~bus.ctrl_we_i & (bus.ctrl_regdest_i != '0);
            regdest_reg     <= bus.ctrl_regdest_i;
         end
         if ((state_reg == WAIT) && bus.data_rvalid_i && ld_write_reg) begin
            wpc_we_reg   <= 1'b1;
            wpc_addr_reg <= regdest_reg;
            wpc_data_reg <= ld_data;
         end
      end
   end

`ifdef JEDRO_1_LSU_MISALIGNED_EXC_EN
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         misaligned_reg <= 1'b0;
      end else begin
         misaligned_reg <= accept & cmd_misaligned;
      end
   end
`endif

   assign bus.ctrl_ready_o = ready;
   assign bus.data_req_o   = (state_reg == REQ);
   assign bus.data_we_o    = data_we_reg;
   assign bus.data_be_o    = data_be_reg;
   assign bus.data_addr_o  = data_addr_reg;
   assign bus.data_wdata_o = data_wdata_reg;
   assign bus.wpc_addr_o   = wpc_addr_reg;
   assign bus.wpc_data_o   = wpc_data_reg;
   assign bus.wpc_we_o     = wpc_we_reg;

endmodule

// File: tb/tb_jedro_1_lsu.sv
// -----------------------------------------------------------------------------
// tb_jedro_1_lsu
// Self-checking bench for jedro_1_lsu: directed cases followed by randomized
// commands with random grant and response latency. Expected bus fields and
// load results come from an arithmetic reference model of the access rules.
// Honours JEDRO_1_LSU_MISALIGNED_EXC_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_jedro_1_lsu;

   logic clk;
   logic rstn;
   int   n_tests;
   int   n_fail;
   int   n_txn;

   jedro_1_lsu_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) bus ();

   jedro_1_lsu #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
      .clk_i  (clk),
      .rstn_i (rstn),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic bit model_mis(input logic [1:0] size, input logic [31:0] addr);
      int o;
      o = int'(addr % 4);
      if (size == 2'd0) return 1'b0;
      if (size == 2'd1) return (o % 2) != 0;
      return o != 0;
   endfunction

   function automatic int model_off(input logic [1:0] size, input logic [31:0] addr);
      int o;
      o = int'(addr % 4);
      if (size == 2'd0) return o;
      if (size == 2'd1) return o - (o % 2);
      return 0;
   endfunction

   function automatic logic [31:0] model_be(input logic [1:0] size, input int o);
      if (size == 2'd0) return 32'(1 << o);
      if (size == 2'd1) return 32'(3 << o);
      return 32'd15;
   endfunction

   function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] w);
      if (size == 2'd0) return (w % 256) * 32'h01010101;
      if (size == 2'd1) return (w % 65536) * 32'h00010001;
      return w;
   endfunction

   function automatic logic [31:0] model_load(input logic [1:0] size, input bit uns,
                                              input int o, input logic [31:0] rdata);
      longint v, m;
      int     n;
      n = (size == 2'd0) ? 8 : (size == 2'd1) ? 16 : 32;
      m = longint'(1) << n;
      v = longint'({32'b0, rdata}) >> (8 * o);
      v = v % m;
      if (!uns && n < 32 && v >= m / 2) v = v - m;
      return 32'(v);
   endfunction

   // ---------------- one complete command ----------------
   task automatic run_txn(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [4:0] rd, input logic [31:0] rdata,
                          input int gd, input int rvd);
      int         o;
      int         waited;
      bit         exp_wr;
      logic [31:0] exp_addr;
      logic [31:0] exp_be;
      waited = 0;
      while (!bus.ctrl_ready_o && waited < 20) begin
         @(posedge clk); #1;
         waited++;
      end
      check_val("ready_before_cmd", 32'(bus.ctrl_ready_o), 32'd1);
      o        = model_off(size, addr);
      exp_addr = addr - (addr % 4);
      exp_be   = model_be(size, o);
      exp_wr   = !we && rd != 0;
      n_txn++;

      bus.ctrl_valid_i    = 1'b1;
      bus.ctrl_we_i       = we;
      bus.ctrl_size_i     = size;
      bus.ctrl_unsigned_i = uns;
      bus.ctrl_addr_i     = addr;
      bus.ctrl_wdata_i    = wdata;
      bus.ctrl_regdest_i  = rd;
      @(posedge clk); #1;
      bus.ctrl_valid_i = 1'b0;

`ifdef JEDRO_1_LSU_MISALIGNED_EXC_EN
      if (model_mis(size, addr)) begin
         check_val("mis_pulse", 32'(bus.misaligned_o), 32'd1);
         check_val("mis_no_req", 32'(bus.data_req_o), 32'd0);
         check_val("mis_ready", 32'(bus.ctrl_ready_o), 32'd1);
         check_val("mis_no_wpc", 32'(bus.wpc_we_o), 32'd0);
         @(posedge clk); #1;
         check_val("mis_pulse_end", 32'(bus.misaligned_o), 32'd0);
         check_val("mis_no_req2", 32'(bus.data_req_o), 32'd0);
         check_val("mis_no_wpc2", 32'(bus.wpc_we_o), 32'd0);
         $display("[TB] txn %0d misaligned we=%0d size=%0d addr=0x%08h", n_txn, we, size, addr);
         return;
      end
`endif

      check_val("req", 32'(bus.data_req_o), 32'd1);
      check_val("addr", bus.data_addr_o, exp_addr);
      check_val("be", 32'(bus.data_be_o), exp_be);
      check_val("we", 32'(bus.data_we_o), 32'(we));
      if (we) check_val("wdata", bus.data_wdata_o, model_wdata(size, wdata));
      check_val("busy_ready", 32'(bus.ctrl_ready_o), 32'd0);
      check_val("no_mis", 32'(bus.misaligned_o), 32'd0);

      // Grant stall: outputs must hold, extra commands and rvalid are ignored.
      for (int i = 0; i < gd; i++) begin
         bus.ctrl_valid_i   = 1'b1;
         bus.ctrl_we_i      = 1'($urandom);
         bus.ctrl_size_i    = 2'($urandom);
         bus.ctrl_addr_i    = $urandom;
         bus.ctrl_regdest_i = 5'($urandom);
         bus.data_rvalid_i  = 1'($urandom);
         bus.data_rdata_i   = $urandom;
         @(posedge clk); #1;
         check_val("stall_req", 32'(bus.data_req_o), 32'd1);
         check_val("stall_addr", bus.data_addr_o, exp_addr);
         check_val("stall_be", 32'(bus.data_be_o), exp_be);
         check_val("stall_ready", 32'(bus.ctrl_ready_o), 32'd0);
      end
      bus.ctrl_valid_i  = 1'b0;
      bus.data_rvalid_i = 1'b0;
      bus.data_gnt_i    = 1'b1;
      @(posedge clk); #1;
      bus.data_gnt_i = 1'b0;
      check_val("req_drop", 32'(bus.data_req_o), 32'd0);
      check_val("wait_ready", 32'(bus.ctrl_ready_o), 32'd0);

      for (int i = 0; i < rvd; i++) begin
         bus.data_gnt_i = 1'($urandom);
         @(posedge clk); #1;
         check_val("wait_ready2", 32'(bus.ctrl_ready_o), 32'd0);
         check_val("wait_no_req", 32'(bus.data_req_o), 32'd0);
      end
      bus.data_gnt_i    = 1'b0;
      bus.data_rvalid_i = 1'b1;
      bus.data_rdata_i  = rdata;
      @(posedge clk); #1;
      bus.data_rvalid_i = 1'b0;
      bus.data_rdata_i  = $urandom;
      check_val("wpc_we", 32'(bus.wpc_we_o), 32'(exp_wr));
      if (exp_wr) begin
         check_val("wpc_addr", 32'(bus.wpc_addr_o), 32'(rd));
         check_val("wpc_data", bus.wpc_data_o, model_load(size, uns, o, rdata));
      end
      check_val("done_ready", 32'(bus.ctrl_ready_o), 32'd1);
      @(posedge clk); #1;
      check_val("wpc_pulse_end", 32'(bus.wpc_we_o), 32'd0);
      $display("[TB] txn %0d we=%0d size=%0d uns=%0d addr=0x%08h rd=%0d gnt_wait=%0d rv_wait=%0d",
               n_txn, we, size, uns, addr, rd, gd, rvd);
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      n_txn   = 0;
      rstn                = 1'b0;
      bus.ctrl_valid_i    = 1'b0;
      bus.ctrl_we_i       = 1'b0;
      bus.ctrl_size_i     = 2'd0;
      bus.ctrl_unsigned_i = 1'b0;
      bus.ctrl_addr_i     = '0;
      bus.ctrl_wdata_i    = '0;
      bus.ctrl_regdest_i  = '0;
      bus.data_gnt_i      = 1'b0;
      bus.data_rvalid_i   = 1'b0;
      bus.data_rdata_i    = '0;

      repeat (3) @(posedge clk);
      #1;
      check_val("rst_ready", 32'(bus.ctrl_ready_o), 32'd0);
      check_val("rst_req", 32'(bus.data_req_o), 32'd0);
      check_val("rst_we", 32'(bus.data_we_o), 32'd0);
      check_val("rst_be", 32'(bus.data_be_o), 32'd0);
      check_val("rst_addr", bus.data_addr_o, 32'd0);
      check_val("rst_wdata", bus.data_wdata_o, 32'd0);
      check_val("rst_wpc_we", 32'(bus.wpc_we_o), 32'd0);
      check_val("rst_wpc_addr", 32'(bus.wpc_addr_o), 32'd0);
      check_val("rst_wpc_data", bus.wpc_data_o, 32'd0);
      check_val("rst_mis", 32'(bus.misaligned_o), 32'd0);
      rstn = 1'b1;
      @(posedge clk); #1;
      check_val("idle_ready", 32'(bus.ctrl_ready_o), 32'd1);

      // Directed cases
      run_txn(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 5'd5, 32'hDEADBEEF, 0, 0);  // LW
      run_txn(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 5'd7, 32'h80FF1234, 0, 0);  // LB
      run_txn(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 5'd7, 32'h80FF1234, 0, 0);  // LBU
      run_txn(1'b1, 2'd1, 1'b0, 32'h102, 32'h0000ABCD, 5'd3, 32'h0, 0, 1);  // SH
      run_txn(1'b0, 2'd1, 1'b0, 32'h206, 32'h0, 5'd9, 32'h8001_7FFF, 4, 2); // LH, gnt stall
      run_txn(1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 5'd4, 32'h12345678, 0, 0);  // LW misaligned
      run_txn(1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 5'd0, 32'hFFFFFFFF, 1, 0);  // load to x0

      // Randomized commands
      for (int i = 0; i < 40; i++) begin
         run_txn(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom,
                 5'($urandom), $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end

      // Reset while waiting for the response; the late rvalid must be dropped.
      bus.ctrl_valid_i    = 1'b1;
      bus.ctrl_we_i       = 1'b0;
      bus.ctrl_size_i     = 2'd2;
      bus.ctrl_addr_i     = 32'h400;
      bus.ctrl_regdest_i  = 5'd12;
      @(posedge clk); #1;
      bus.ctrl_valid_i = 1'b0;
      check_val("rstwait_req", 32'(bus.data_req_o), 32'd1);
      bus.data_gnt_i = 1'b1;
      @(posedge clk); #1;
      bus.data_gnt_i = 1'b0;
      rstn = 1'b0;
      @(posedge clk); #1;
      check_val("rstwait_req_low", 32'(bus.data_req_o), 32'd0);
      check_val("rstwait_ready_low", 32'(bus.ctrl_ready_o), 32'd0);
      check_val("rstwait_be", 32'(bus.data_be_o), 32'd0);
      rstn              = 1'b1;
      bus.data_rvalid_i = 1'b1;
      bus.data_rdata_i  = 32'hCAFEF00D;
      @(posedge clk); #1;
      bus.data_rvalid_i = 1'b0;
      check_val("rstwait_no_wpc", 32'(bus.wpc_we_o), 32'd0);
      check_val("rstwait_ready", 32'(bus.ctrl_ready_o), 32'd1);
      check_val("rstwait_no_req", 32'(bus.data_req_o), 32'd0);
      @(posedge clk); #1;
      check_val("rstwait_no_wpc2", 32'(bus.wpc_we_o), 32'd0);
      $display("[TB] txn %0d reset during WAIT", n_txn + 1);

      // A normal load still works after the mid-operation reset.
      run_txn(1'b0, 2'd1, 1'b1, 32'h502, 32'h0, 5'd31, 32'hBEEF1111, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
